// File: rtl/button_event_decoder_if.sv
// Bundles the button-decoder signals: the debounced level and shared 10 ms
// tick going in, and the one-cycle event pulses plus the held level coming out.
interface button_event_decoder_if;
    logic i_level;
    logic i_tick10ms;
    logic o_press;
    logic o_short;
    logic o_long;
    logic o_repeat;
    logic o_held;

    // Upstream side: drives the level and tick, observes the events.
    modport master (
        output i_level,
        output i_tick10ms,
        input  o_press,
        input  o_short,
        input  o_long,
        input  o_repeat,
        input  o_held
    );

    // Decoder side: consumes the level and tick, produces the events.
    modport slave (
        input  i_level,
        input  i_tick10ms,
        output o_press,
        output o_short,
        output o_long,
        output o_repeat,
        output o_held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button actuations into press / short / long events,
// counting the hold time in 10 ms ticks. All outputs are registered.
// Optional auto-repeat while a long press is held is compiled in when the
// macro BUTTON_EVENT_DECODER_REPEAT_EN is defined; otherwise o_repeat is 0.
module button_event_decoder #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_decoder_if.slave  bus
);
    // The counter is shared between the long threshold and the repeat period.
    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            level_q_reg;
    logic            press_reg, press_next;
    logic            short_reg, short_next;
    logic            long_reg, long_next;
    logic            held_reg, held_next;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
    logic            repeat_reg, repeat_next;
`endif

    logic rise;
    logic fall;

    // Edges alternate strictly because level_q_reg tracks the input every cycle.
    assign rise = bus.i_level & ~level_q_reg;
    assign fall = ~bus.i_level & level_q_reg;

    // State, counter, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_q_reg <= 1'b0;
            press_reg   <= 1'b0;
            short_reg   <= 1'b0;
            long_reg    <= 1'b0;
            held_reg    <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            repeat_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_q_reg <= bus.i_level;
            press_reg   <= press_next;
            short_reg   <= short_next;
            long_reg    <= long_next;
            held_reg    <= held_next;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            repeat_reg  <= repeat_next;
`endif
        end
    end

    // Next-state and next-output logic; a release always beats a coincident tick.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_next  = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
        repeat_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end else if (bus.i_tick10ms) begin
                    if (cnt_reg == CW'(LONG_TICKS - 1)) begin
                        state_next = LONG;
                        cnt_next   = '0;
                        long_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_next = IDLE;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
                end else if (bus.i_tick10ms) begin
                    if (cnt_reg == CW'(REPEAT_TICKS - 1)) begin
                        cnt_next    = '0;
                        repeat_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        held_next = (state_next == LONG);
    end

    assign bus.o_press  = press_reg;
    assign bus.o_short  = short_reg;
    assign bus.o_long   = long_reg;
    assign bus.o_held   = held_reg;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
    assign bus.o_repeat = repeat_reg;
`else
    assign bus.o_repeat = 1'b0;
`endif

endmodule
